// File: rtl/uart_msg_tx_if.sv
// Signal bundle between the message transmitter and its ROM and host.
// master is the transmitter side; slave is the ROM/host side.
interface uart_msg_tx_if #(
    parameter int ADDR_W = 8
);
    logic              start;
    logic [ADDR_W-1:0] address;
    logic [7:0]        data;
    logic              tx;
    logic              idle;
    logic              done;

    modport master (
        input  start,
        input  data,
        output address,
        output tx,
        output idle,
        output done
    );

    modport slave (
        output start,
        output data,
        input  address,
        input  tx,
        input  idle,
        input  done
    );
endinterface

// File: rtl/uart_msg_tx.sv
// UART transmitter that streams a zero-terminated message from a combinational ROM.
// Each byte costs one FETCH cycle plus a start/data/parity/stop frame.
module uart_msg_tx #(
    parameter int CLK_DIV   = 4,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1,
    parameter int ADDR_W    = 8,
    parameter int MAX_LEN   = 256
) (
    input  logic          clk,
    input  logic          rst,
    uart_msg_tx_if.master bus
);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [2:0]        DBIT_LAST = 3'(DATA_BITS - 1);
    localparam logic [2:0]        SBIT_LAST = 3'(STOP_BITS - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(MAX_LEN - 1);
    localparam logic              PAR_ODD   = (PARITY == 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                r_state,   w_state_next;
    logic                  r_start_q;
    logic [ADDR_W-1:0]     r_addr,    w_addr_next;
    logic                  r_tx,      w_tx_next;
    logic                  r_idle,    w_idle_next;
    logic                  r_done,    w_done_next;
    logic [DIV_W-1:0]      r_div,     w_div_next;
    logic [2:0]            r_bit,     w_bit_next;
    logic [DATA_BITS-1:0]  r_shift,   w_shift_next;
    logic                  r_par,     w_par_next;
    logic                  w_bit_end;

    assign w_bit_end = (r_div == DIV_LAST);

    always_comb begin
        w_state_next = r_state;
        w_addr_next  = r_addr;
        w_tx_next    = r_tx;
        w_idle_next  = r_idle;
        w_done_next  = 1'b0;
        w_div_next   = '0;
        w_bit_next   = r_bit;
        w_shift_next = r_shift;
        w_par_next   = r_par;
        // divider restarts at every bit boundary so bit lengths never drift
        if (r_state != S_IDLE && r_state != S_FETCH && !w_bit_end)
            w_div_next = r_div + 1'b1;
        case (r_state)
            S_IDLE: begin
                w_tx_next = 1'b1;
                if (bus.start && !r_start_q) begin
                    w_state_next = S_FETCH;
                    w_addr_next  = '0;
                    w_idle_next  = 1'b0;
                end
            end
            S_FETCH: begin
                if (bus.data == 8'h00) begin
                    w_state_next = S_IDLE;
                    w_idle_next  = 1'b1;
                    w_done_next  = 1'b1;
                end else begin
                    w_state_next = S_START;
                    w_tx_next    = 1'b0;
                    w_shift_next = bus.data[DATA_BITS-1:0];
                    w_par_next   = (^bus.data[DATA_BITS-1:0]) ^ PAR_ODD;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_state_next = S_DATA;
                    w_tx_next    = r_shift[0];
                    w_shift_next = r_shift >> 1;
                    w_bit_next   = '0;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    if (r_bit == DBIT_LAST) begin
                        w_bit_next = '0;
                        if (PARITY != 0) begin
                            w_state_next = S_PARITY;
                            w_tx_next    = r_par;
                        end else begin
                            w_state_next = S_STOP;
                            w_tx_next    = 1'b1;
                        end
                    end else begin
                        w_tx_next    = r_shift[0];
                        w_shift_next = r_shift >> 1;
                        w_bit_next   = r_bit + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (w_bit_end) begin
                    w_state_next = S_STOP;
                    w_tx_next    = 1'b1;
                    w_bit_next   = '0;
                end
            end
            S_STOP: begin
                w_tx_next = 1'b1;
                if (w_bit_end) begin
                    if (r_bit != SBIT_LAST) begin
                        w_bit_next = r_bit + 1'b1;
                    end else if (r_addr == ADDR_LAST) begin
                        // length cap reached: finish without fetching a terminator
                        w_state_next = S_IDLE;
                        w_idle_next  = 1'b1;
                        w_done_next  = 1'b1;
                    end else begin
                        w_state_next = S_FETCH;
                        w_addr_next  = r_addr + 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_tx_next    = 1'b1;
                w_idle_next  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_start_q <= 1'b1;
            r_addr    <= '0;
            r_tx      <= 1'b1;
            r_idle    <= 1'b1;
            r_done    <= 1'b0;
            r_div     <= '0;
            r_bit     <= '0;
            r_shift   <= '0;
            r_par     <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_start_q <= bus.start;
            r_addr    <= w_addr_next;
            r_tx      <= w_tx_next;
            r_idle    <= w_idle_next;
            r_done    <= w_done_next;
            r_div     <= w_div_next;
            r_bit     <= w_bit_next;
            r_shift   <= w_shift_next;
            r_par     <= w_par_next;
        end
    end

    assign bus.address = r_addr;
    assign bus.tx      = r_tx;
    assign bus.idle    = r_idle;
    assign bus.done    = r_done;
endmodule

// File: tb/tb_uart_msg_tx.sv
// Bench for uart_msg_tx: three configurations, a message table and a byte scoreboard.
// Frames are decoded from tx and compared with bytes queued when start is raised.
module tb_uart_msg_tx;
    typedef struct {
        int    w;
        string msg;
        int    n_frames;
        int    done_off;
        int    final_addr;
        int    first_bits;
        int    toggle_k;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    int         cyc = 0;
    int         n_pass = 0;
    int         n_total = 0;
    logic [7:0] sb_q[$];
    logic [7:0] rom0 [256];
    logic [7:0] rom1 [256];
    logic [7:0] rom2 [256];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_msg_tx_if #(.ADDR_W(8)) bus0 ();
    uart_msg_tx_if #(.ADDR_W(8)) bus1 ();
    uart_msg_tx_if #(.ADDR_W(8)) bus2 ();

    assign bus0.data = rom0[bus0.address];
    assign bus1.data = rom1[bus1.address];
    assign bus2.data = rom2[bus2.address];

    uart_msg_tx #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .ADDR_W(8), .MAX_LEN(256))
        u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
    uart_msg_tx #(.CLK_DIV(3), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .ADDR_W(8), .MAX_LEN(256))
        u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
    uart_msg_tx #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .ADDR_W(8), .MAX_LEN(4))
        u_dut2 (.clk(clk), .rst(rst), .bus(bus2));

    function automatic int cd_of(int w);  return (w == 1) ? 3 : 4; endfunction
    function automatic int db_of(int w);  return (w == 1) ? 7 : 8; endfunction
    function automatic int par_of(int w); return (w == 1) ? 2 : 0; endfunction
    function automatic int sb_of(int w);  return (w == 1) ? 2 : 1; endfunction

    function automatic logic get_tx(int w);
        case (w)
            0:       return bus0.tx;
            1:       return bus1.tx;
            default: return bus2.tx;
        endcase
    endfunction

    function automatic logic get_idle(int w);
        case (w)
            0:       return bus0.idle;
            1:       return bus1.idle;
            default: return bus2.idle;
        endcase
    endfunction

    function automatic logic get_done(int w);
        case (w)
            0:       return bus0.done;
            1:       return bus1.done;
            default: return bus2.done;
        endcase
    endfunction

    function automatic int get_addr(int w);
        case (w)
            0:       return int'(bus0.address);
            1:       return int'(bus1.address);
            default: return int'(bus2.address);
        endcase
    endfunction

    task automatic set_start(input int w, input logic v);
        case (w)
            0:       bus0.start = v;
            1:       bus1.start = v;
            default: bus2.start = v;
        endcase
    endtask

    task automatic load_rom(input int w, input string s);
        logic [7:0] b;
        for (int i = 0; i < 256; i++) begin
            b = (i < s.len()) ? 8'(s[i]) : 8'h00;
            case (w)
                0:       rom0[i] = b;
                1:       rom1[i] = b;
                default: rom2[i] = b;
            endcase
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Decode one frame from tx, checking timing, hold, parity and stop bits.
    task automatic rx_frame(input int w, input int k, input int e0, input int tgl, output int bits_o);
        int         cd, db, par, sb, f, p, guard, t0;
        logic [15:0] bits;
        logic       hold_ok, addr_ok, quiet_ok, stop_ok;
        logic [7:0] got, expb, mask;
        cd  = cd_of(w);
        db  = db_of(w);
        par = par_of(w);
        sb  = sb_of(w);
        f   = 1 + db + ((par != 0) ? 1 : 0) + sb;
        p   = f * cd + 1;
        guard = 0;
        while (get_tx(w) !== 1'b0 && guard < 2 * p) begin
            @(negedge clk);
            guard++;
        end
        chk("frame_timeout", (guard < 2 * p) ? 1 : 0, 1);
        t0 = cyc;
        chk("frame_start_cycle", t0 - e0, 1 + k * p);
        bits = '0;
        hold_ok = 1'b1;
        addr_ok = 1'b1;
        quiet_ok = 1'b1;
        for (int j = 0; j < f; j++) begin
            for (int c = 0; c < cd; c++) begin
                if (c == 0) bits[j] = get_tx(w);
                else if (get_tx(w) !== bits[j]) hold_ok = 1'b0;
                if (get_addr(w) != k) addr_ok = 1'b0;
                if (get_idle(w) !== 1'b0 || get_done(w) !== 1'b0) quiet_ok = 1'b0;
                if (k == tgl && c == 0 && j == 1) set_start(w, 1'b0);
                if (k == tgl && c == 0 && j == 3) set_start(w, 1'b1);
                @(negedge clk);
            end
        end
        chk("bit_hold", int'(hold_ok), 1);
        chk("frame_addr", int'(addr_ok), 1);
        chk("busy_flags", int'(quiet_ok), 1);
        mask = 8'((16'd1 << db) - 16'd1);
        got  = 8'(bits >> 1) & mask;
        chk("sb_nonempty", (sb_q.size() > 0) ? 1 : 0, 1);
        expb = (sb_q.size() > 0) ? sb_q.pop_front() : 8'h00;
        chk("frame_data", int'(got), int'(expb & mask));
        if (par != 0)
            chk("parity_bit", int'(bits[1 + db]), int'((^got) ^ ((par == 1) ? 1'b1 : 1'b0)));
        stop_ok = 1'b1;
        for (int s = 0; s < sb; s++)
            if (bits[f - sb + s] !== 1'b1) stop_ok = 1'b0;
        chk("stop_bits", int'(stop_ok), 1);
        bits_o = int'(bits);
    endtask

    task automatic run_msg(input vec_t v);
        int e0, guard, bits, bad;
        load_rom(v.w, v.msg);
        for (int i = 0; i < v.n_frames; i++) sb_q.push_back(8'(v.msg[i]));
        @(negedge clk);
        set_start(v.w, 1'b1);
        @(posedge clk);
        #1;
        e0 = cyc;
        @(negedge clk);
        chk("accept_idle", int'(get_idle(v.w)), 0);
        chk("accept_addr", get_addr(v.w), 0);
        chk("fetch_tx", int'(get_tx(v.w)), 1);
        for (int k = 0; k < v.n_frames; k++) begin
            rx_frame(v.w, k, e0, v.toggle_k, bits);
            if (k == 0 && v.first_bits >= 0) chk("first_frame_bits", bits, v.first_bits);
        end
        guard = 0;
        while (get_done(v.w) !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk("done_seen", (guard < 100) ? 1 : 0, 1);
        chk("done_cycle", cyc - e0, v.done_off);
        chk("done_idle", int'(get_idle(v.w)), 1);
        chk("done_tx", int'(get_tx(v.w)), 1);
        chk("final_addr", get_addr(v.w), v.final_addr);
        @(negedge clk);
        chk("done_width", int'(get_done(v.w)), 0);
        bad = 0;
        repeat (12) begin
            if (get_idle(v.w) !== 1'b1 || get_tx(v.w) !== 1'b1) bad++;
            @(negedge clk);
        end
        chk("no_retrigger", bad, 0);
        set_start(v.w, 1'b0);
        repeat (2) @(negedge clk);
        chk("sb_drained", sb_q.size(), 0);
        $display("msg dut%0d \"%s\" frames=%0d done at E0+%0d", v.w, v.msg, v.n_frames, v.done_off);
    endtask

    initial begin : main
        vec_t vecs[8];
        vec_t after_rst;
        int   bad, e0;
        vecs[0] = '{0, "Hello, World!", 13, 534, 13, 656, -1};
        vecs[1] = '{0, "",              0,  1,   0,  -1,  -1};
        vecs[2] = '{0, "A",             1,  42,  1,  -1,  -1};
        vecs[3] = '{0, "ABCD",          4,  165, 4,  -1,  1};
        vecs[4] = '{0, "ABCD",          4,  165, 4,  -1,  -1};
        vecs[5] = '{1, "A",             1,  35,  1,  1666, -1};
        vecs[6] = '{1, "Hi",            2,  69,  2,  -1,  -1};
        vecs[7] = '{2, "UUUUUUUU",      4,  164, 3,  -1,  -1};
        after_rst = '{0, "Hi", 2, 83, 2, -1, -1};

        load_rom(0, "");
        load_rom(1, "");
        load_rom(2, "");
        bus0.start = 1'b1;
        bus1.start = 1'b0;
        bus2.start = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int w = 0; w < 3; w++) begin
            chk("reset_tx", int'(get_tx(w)), 1);
            chk("reset_idle", int'(get_idle(w)), 1);
            chk("reset_done", int'(get_done(w)), 0);
            chk("reset_addr", get_addr(w), 0);
        end
        load_rom(0, "Hello, World!");
        rst = 1'b0;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (get_idle(0) !== 1'b1 || get_tx(0) !== 1'b1) bad++;
        end
        chk("start_held_through_reset", bad, 0);
        set_start(0, 1'b0);
        repeat (2) @(negedge clk);

        for (int i = 0; i < 8; i++) run_msg(vecs[i]);

        // asynchronous reset in the middle of data bit 0 of 'H'
        load_rom(0, "Hello, World!");
        set_start(0, 1'b1);
        @(posedge clk);
        #1;
        e0 = cyc;
        while (cyc < e0 + 6) @(negedge clk);
        chk("pre_reset_tx", int'(get_tx(0)), 0);
        #2;
        rst = 1'b1;
        #1;
        chk("async_reset_tx", int'(get_tx(0)), 1);
        chk("async_reset_idle", int'(get_idle(0)), 1);
        chk("async_reset_addr", get_addr(0), 0);
        chk("async_reset_done", int'(get_done(0)), 0);
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (get_idle(0) !== 1'b1 || get_tx(0) !== 1'b1) bad++;
        end
        chk("no_start_after_reset", bad, 0);
        $display("reset mid-frame on dut0, start held high");
        set_start(0, 1'b0);
        repeat (2) @(negedge clk);
        run_msg(after_rst);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/uart_msg_tx.md
# uart_msg_tx

Parametrised UART transmitter that streams a zero-terminated byte message from an external combinational ROM. On a start request it walks addresses from 0 and serialises each byte until it reads a 0x00 terminator or has sent MAX_LEN bytes. It then reports completion. It adds configurable baud divider, word length, parity, stop bits, length cap, reset and a done pulse.

## Interface
Parameters:
- CLK_DIV, 4: clk cycles per serial bit (≥1).
- DATA_BITS, 8: transmitted data bits per byte (5..8).
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: stop bits per frame (1 or 2).
- ADDR_W, 8: message address width.
- MAX_LEN, 256: maximum bytes sent per message (1..2^ADDR_W).

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  message request; only a 0→1 transition of the sampled level is acted on.
- address  out  ADDR_W  ROM address of the byte being fetched or sent.
- data  in  8  ROM byte at address; combinational, valid in the same cycle.
- tx  out  1  serial line; idles high.
- idle  out  1  high when no message is in progress.
- done  out  1  one-cycle pulse when a message finishes.

## Operation
- Reset values: tx=1, idle=1, done=0, address=0, state IDLE, start_q=1.
  - start_q=1 means a start held high through reset release does not trigger.
- start_q registers start every cycle, including while busy.
- Accept: in IDLE, an edge where start=1 and start_q=0 goes to FETCH. On that edge address=0 and idle=0.
  - Requests during a message are ignored, never queued. A rise during busy is lost.
- States:
  - IDLE
  - FETCH: 1 cycle; data is sampled at the end of the cycle.
  - START
  - DATA
  - PARITY: only if PARITY≠0.
  - STOP
- FETCH:
  - If data==8'h00 (all 8 bits compared, regardless of DATA_BITS): go to IDLE, idle=1, done=1.
  - Otherwise load data[DATA_BITS-1:0] into the shift register and go to START.
- START: tx=0 for CLK_DIV cycles.
- DATA: DATA_BITS bits, LSB first, each held for CLK_DIV cycles. Bits above DATA_BITS are discarded.
- PARITY bit: XOR of the sent data bits for even, inverted for odd. Held for CLK_DIV cycles.
- STOP: tx=1 for STOP_BITS×CLK_DIV cycles. At its end:
  - If bytes sent == MAX_LEN: go to IDLE with done=1; no terminator fetch.
  - Otherwise address+1 and go to FETCH.
- address is held constant for the whole frame of the byte being sent. It never exceeds MAX_LEN-1 and never wraps.
- tx is registered and is 1 in IDLE and FETCH.
- Bit timing uses a divider counter 0..CLK_DIV-1 that restarts at every bit boundary. There is no drift between bits.

## Timing
- Let E0 be the accept edge.
  - data[0] is sampled at E0+1. If non-zero, tx falls at E0+1.
- Frame: F = 1 + DATA_BITS + (PARITY≠0) + STOP_BITS bits. Byte period P = F×CLK_DIV + 1 cycles, the +1 being FETCH.
- Byte k's start bit begins at edge E0+1+k×P.
- Terminated message of N bytes: done and idle rise at E0+1+N×P.
- Capped message (N=MAX_LEN): done and idle rise at E0+N×P.
- done lasts exactly one cycle. The next accept is possible on the edge after done if start rises.
- Empty message (data[0]=0): idle is low for 1 cycle; done at E0+1; tx never leaves 1.
- rst mid-operation: tx=1, idle=1, done=0, address=0 immediately, without waiting for a clock edge. No partial frame resumes.
- start and rst only ever act on or via clk edges, except the asynchronous reset itself.

## Test plan
- Defaults, ROM "Hello, World!\0", start rises and stays high:
  - tx falls 1 cycle after accept.
  - First frame 0,0,0,0,1,0,0,1,0,1 (0x48 LSB first), 4 cycles per bit.
  - P=41; 13 frames decode to "Hello, World!".
  - done pulses once at E0+534; no second message while start remains high.
- ROM byte 0 = 0x00:
  - done at E0+1; idle low exactly 1 cycle; tx constant 1.
- DATA_BITS=7, PARITY=2, STOP_BITS=2, CLK_DIV=3, ROM "A\0":
  - tx = 0,1,0,0,0,0,0,1,0,1,1; each bit 3 cycles; P=34.
  - done at E0+35.
- MAX_LEN=4, ROM all 0x55:
  - Exactly 4 frames; address steps 0..3, never 4.
  - With defaults, done at E0+164.
- Start edge handling:
  - Lower start, raise it during frame 2: ignored.
  - Lower and raise start after done: second identical message, address restarting at 0.
- Assert rst mid data bit with start held high:
  - tx=1 and idle=1 before the next clk edge, address=0.
  - After release, no message until start goes low then high.
